// File: rtl/sop_pipe_pkg.sv
// Shared constants and term indexing for the pipelined SOP gate array.
// Default parameter values; term_off locates a product term inside in_data.
package sop_pipe_pkg;
  localparam int DEF_CHANNELS = 2;
  localparam int DEF_TERMS    = 2;
  localparam int DEF_TERM_W   = 3;
  localparam int DEF_CNT_W    = 16;

  function automatic int term_off(
    input int c,
    input int t,
    input int terms,
    input int tw
  );
    return (c * terms + t) * tw;
  endfunction
endpackage

// File: rtl/sop_pipe_stage.sv
// Generic valid/ready register slice.
// Loads whenever empty or drained downstream in the same cycle.
module sop_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  assign in_ready = !out_valid | out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end
endmodule

// File: rtl/sop_pipe_array.sv
// Pipelined AND-OR / AND-OR-INVERT array with transfer counter.
// Define SOP_TERM_MASK_EN to add a runtime per-term enable mask.
module sop_pipe_array
  import sop_pipe_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int TERMS    = DEF_TERMS,
  parameter int TERM_W   = DEF_TERM_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef SOP_TERM_MASK_EN
  input  logic                         cfg_we,
  input  logic [CHANNELS*TERMS-1:0]    cfg_mask,
`endif
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*TERMS*TERM_W-1:0] in_data,
  input  logic [CHANNELS-1:0]          in_inv,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS-1:0]          out_y,
  output logic [CNT_W-1:0]             xfer_cnt
);
  localparam int NT  = CHANNELS * TERMS;
  localparam int S1W = NT + CHANNELS;

  logic [NT-1:0]       mask;
  logic [NT-1:0]       terms;
  logic [NT-1:0]       s1_terms;
  logic [CHANNELS-1:0] s1_inv;
  logic [S1W-1:0]      s1_q;
  logic                s1_valid;
  logic                s2_ready;
  logic [CHANNELS-1:0] sop;

`ifdef SOP_TERM_MASK_EN
  logic [NT-1:0] mask_q;

  // Accepting beat sees the old mask; update lands on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mask_q <= '1;
    else if (cfg_we) mask_q <= cfg_mask;
  end

  assign mask = mask_q;
`else
  assign mask = '1;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    for (genvar t = 0; t < TERMS; t++) begin : g_t
      localparam int OFF = term_off(c, t, TERMS, TERM_W);
      assign terms[c*TERMS+t] =
        (&in_data[OFF +: TERM_W]) & mask[c*TERMS+t];
    end
  end

  sop_pipe_stage #(.W(S1W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_inv, terms}),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_q)
  );

  assign s1_terms = s1_q[NT-1:0];
  assign s1_inv   = s1_q[S1W-1:NT];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_or
    assign sop[c] = (|s1_terms[c*TERMS +: TERMS]) ^ s1_inv[c];
  end

  sop_pipe_stage #(.W(CHANNELS)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (sop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) xfer_cnt <= '0;
    else if (out_valid && out_ready) xfer_cnt <= xfer_cnt + 1'b1;
  end
endmodule

// File: tb/tb_sop_pipe_array.sv
// Directed + randomized bench for sop_pipe_array against a queue model.
// Mask checks run only when SOP_TERM_MASK_EN is defined.
module tb_sop_pipe_array;
  localparam int CH = 2;
  localparam int T  = 2;
  localparam int W  = 3;
  localparam int NT = CH * T;
  localparam int DW = NT * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CH-1:0] in_inv = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CH-1:0] out_y;
  logic [15:0]   xfer_cnt;

  logic          v2 = 1'b0;
  logic          rdy2;
  logic          ov2;
  logic [CH-1:0] y2;
  logic [1:0]    cnt2;

`ifdef SOP_TERM_MASK_EN
  logic          cfg_we = 1'b0;
  logic [NT-1:0] cfg_mask = '1;
  logic          pend_we = 1'b0;
  logic [NT-1:0] pend_mask = '1;
`endif

  sop_pipe_array #(.CHANNELS(CH), .TERMS(T), .TERM_W(W), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef SOP_TERM_MASK_EN
    .cfg_we    (cfg_we),
    .cfg_mask  (cfg_mask),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .xfer_cnt  (xfer_cnt)
  );

  sop_pipe_array #(.CHANNELS(CH), .TERMS(T), .TERM_W(W), .CNT_W(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
`ifdef SOP_TERM_MASK_EN
    .cfg_we    (1'b0),
    .cfg_mask  ({NT{1'b1}}),
`endif
    .in_valid  (v2),
    .in_ready  (rdy2),
    .in_data   ({DW{1'b1}}),
    .in_inv    (2'b00),
    .out_valid (ov2),
    .out_ready (1'b1),
    .out_y     (y2),
    .xfer_cnt  (cnt2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] y;
    int            e;
  } item_t;

  item_t         q[$];
  int            edges = 0;
  int            mcnt = 0;
  logic [NT-1:0] mmask = '1;
  int            checks = 0;
  int            failures = 0;

  function automatic logic [CH-1:0] ref_y(
    input logic [DW-1:0] d,
    input logic [CH-1:0] inv,
    input logic [NT-1:0] m
  );
    logic [CH-1:0] r;
    logic any;
    logic p;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      any = 1'b0;
      for (int t = 0; t < T; t++) begin
        p = m[c*T+t];
        for (int b = 0; b < W; b++) p = p & d[(c*T+t)*W+b];
        any = any | p;
      end
      r[c] = any ^ inv[c];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check against model, advance model at the edge.
  task automatic step(input logic v, input logic [DW-1:0] d,
                      input logic [CH-1:0] inv, input logic ordy,
                      output logic acc);
    logic ev;
    logic er;
    logic ohs;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_inv    = inv;
    out_ready = ordy;
`ifdef SOP_TERM_MASK_EN
    cfg_we   = pend_we;
    cfg_mask = pend_mask;
`endif
    #1;
    ev = (q.size() > 0) && (q[0].e < edges);
    er = (q.size() < 2) || ordy;
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("xfer_cnt", 32'(xfer_cnt), 32'(mcnt));
    if (ev) chk("out_y", 32'(out_y), 32'(q[0].y));
    ohs = ev && ordy;
    acc = v && er;
    @(posedge clk);
    edges++;
    if (ohs) begin
      void'(q.pop_front());
      mcnt = (mcnt + 1) % 65536;
    end
    if (acc) q.push_back('{ref_y(d, inv, mmask), edges});
`ifdef SOP_TERM_MASK_EN
    if (pend_we) mmask = pend_mask;
`endif
  endtask

  task automatic drain(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, a);
  endtask

  initial begin
    logic a;
    logic [DW-1:0] d;
    int c0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // AO and AOI on the same product pattern
    step(1'b1, 12'b000000_101111, 2'b00, 1'b1, a);
    step(1'b0, '0, '0, 1'b1, a);
    #1 chk("t1_out_y", 32'(out_y), 32'b01);
    drain(2);
    chk("t1_cnt", 32'(xfer_cnt), 32'd1);
    step(1'b1, 12'b000000_101111, 2'b11, 1'b1, a);
    step(1'b0, '0, '0, 1'b1, a);
    #1 chk("t2_out_y", 32'(out_y), 32'b10);
    drain(2);

    c0 = mcnt;
    for (int i = 0; i < 8; i++)
      step(1'b1, DW'($urandom), CH'($urandom), 1'b1, a);
    drain(3);
    chk("t3_cnt8", 32'(mcnt - c0), 32'd8);

    // Stall: two accepted, third refused until downstream drains
    for (int i = 0; i < 2; i++)
      step(1'b1, DW'($urandom), CH'($urandom), 1'b0, a);
    d = DW'($urandom);
    for (int i = 0; i < 3; i++) step(1'b1, d, 2'b01, 1'b0, a);
    a = 1'b0;
    for (int i = 0; i < 4 && !a; i++) step(1'b1, d, 2'b01, 1'b1, a);
    chk("t4_third_accepted", 32'(a), 32'd1);
    drain(4);

    // Reset with beats in flight
    step(1'b1, DW'($urandom), 2'b00, 1'b1, a);
    step(1'b1, DW'($urandom), 2'b00, 1'b1, a);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_cnt", 32'(xfer_cnt), 32'd0);
    q.delete();
    mcnt = 0;
    @(negedge clk);
    rst = 1'b0;
    drain(3);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, DW'($urandom), CH'($urandom),
           $urandom_range(0, 3) != 0, a);
    drain(4);
    chk("rand_empty", 32'(out_valid), 32'd0);

`ifdef SOP_TERM_MASK_EN
    pend_we = 1'b1;
    pend_mask = 4'b1110;
    step(1'b1, 12'b000000_000111, 2'b00, 1'b1, a);
    pend_we = 1'b0;
    step(1'b1, 12'b000000_000111, 2'b00, 1'b1, a);
    #1 chk("t6_old_mask", 32'(out_y), 32'b01);
    step(1'b0, '0, '0, 1'b1, a);
    #1 chk("t6_mask_1110", 32'(out_y), 32'b00);
    pend_we = 1'b1;
    pend_mask = 4'b1111;
    step(1'b1, 12'b000000_000111, 2'b00, 1'b1, a);
    pend_we = 1'b0;
    step(1'b0, '0, '0, 1'b1, a);
    #1 chk("t6_mask_1111", 32'(out_y), 32'b01);
    drain(3);
`endif

    // 2-bit counter wraps after four transfers
    @(negedge clk);
    v2 = 1'b1;
    repeat (5) @(negedge clk);
    v2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_wrap_cnt2", 32'(cnt2), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
